// File: rtl/sd_access_scheduler_if.sv
// rtl/sd_access_scheduler_if.sv - client request bus plus SD controller start/busy handshake
// The master side is the scheduler; the slave side is the clients and the SD controller.
interface sd_access_scheduler_if;
   logic [1:0]  req;
   logic [1:0]  wr;
   logic [63:0] addr;
   logic [15:0] cnt;
   logic [1:0]  ack;
   logic [1:0]  done;
   logic [1:0]  err;
   logic [1:0]  grant;
   logic        wr_start_en;
   logic        rd_start_en;
   logic [31:0] wr_sec_addr;
   logic [31:0] rd_sec_addr;
   logic        wr_busy;
   logic        rd_busy;

   modport master (
      input  req, wr, addr, cnt, wr_busy, rd_busy,
      output ack, done, err, grant, wr_start_en, rd_start_en, wr_sec_addr, rd_sec_addr
   );

   modport slave (
      output req, wr, addr, cnt, wr_busy, rd_busy,
      input  ack, done, err, grant, wr_start_en, rd_start_en, wr_sec_addr, rd_sec_addr
   );
endinterface

// File: rtl/sd_access_scheduler.sv
// rtl/sd_access_scheduler.sv - two-client round-robin scheduler issuing single-sector SD transfers
// A transfer is split into sectors; each sector is one start pulse followed by a busy high/low cycle.
module sd_access_scheduler #(
   parameter int unsigned START_TIMEOUT = 1000,
   parameter int unsigned XFER_TIMEOUT  = 4000000
) (
   input  logic                     clk_sd,
   input  logic                     reset_n,
   input  logic                     sd_init_done,
   sd_access_scheduler_if.master    bus
);

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      START,
      WAIT_BUSY,
      XFER,
      DONE,
      ERR
   } state_t;

   localparam logic [23:0] START_LIMIT = 24'(START_TIMEOUT - 1);
   localparam logic [23:0] XFER_LIMIT  = 24'(XFER_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic        last_q, last_d;
   logic        cur_wr_q, cur_wr_d;
   logic [31:0] cur_addr_q, cur_addr_d;
   logic [7:0]  remaining_q, remaining_d;
   logic [23:0] tmr_q, tmr_d;

   logic        busy_sel;
   logic [1:0]  owner;
   logic [7:0]  sel_cnt;
   logic [31:0] sel_addr;

   assign busy_sel = cur_wr_q ? bus.wr_busy : bus.rd_busy;
   assign owner    = sel_q ? 2'b10 : 2'b01;
   assign sel_cnt  = sel_q ? bus.cnt[15:8] : bus.cnt[7:0];
   assign sel_addr = sel_q ? bus.addr[63:32] : bus.addr[31:0];

   always_ff @(posedge clk_sd) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         last_q      <= 1'b1;
         cur_wr_q    <= 1'b0;
         cur_addr_q  <= 32'd0;
         remaining_q <= 8'd0;
         tmr_q       <= 24'd0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         cur_wr_q    <= cur_wr_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         tmr_q       <= tmr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      cur_wr_d    = cur_wr_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;

      case (state_q)
         IDLE: begin
            if (sd_init_done && (bus.req != 2'b00)) begin
               state_d = ACCEPT;
               case (bus.req)
                  2'b01:   sel_d = 1'b0;
                  2'b10:   sel_d = 1'b1;
                  default: sel_d = ~last_q;
               endcase
            end
         end
         ACCEPT: begin
            cur_wr_d    = bus.wr[sel_q];
            cur_addr_d  = sel_addr;
            remaining_d = sel_cnt;
            state_d     = (sel_cnt == 8'd0) ? DONE : START;
         end
         START: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (busy_sel) begin
               state_d = XFER;
            end else if (tmr_q >= START_LIMIT) begin
               state_d = ERR;
            end
         end
         XFER: begin
            if (!busy_sel) begin
               remaining_d = remaining_q - 8'd1;
               cur_addr_d  = cur_addr_q + 32'd1;
               state_d     = (remaining_q == 8'd1) ? DONE : START;
            end else if (tmr_q >= XFER_LIMIT) begin
               state_d = ERR;
            end
         end
         DONE, ERR: begin
            last_d  = sel_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Losing the card aborts any in-flight transfer; DONE/ERR already finish this cycle.
      if (!sd_init_done && (state_q inside {ACCEPT, START, WAIT_BUSY, XFER})) begin
         state_d = ERR;
      end
   end

   always_comb begin
      tmr_d = 24'd0;
      if ((state_d == state_q) && (state_q inside {WAIT_BUSY, XFER})) begin
         tmr_d = tmr_q + 24'd1;
      end
   end

   always_comb begin
      bus.ack   = 2'b00;
      bus.done  = 2'b00;
      bus.err   = 2'b00;
      bus.grant = 2'b00;
      if (state_q != IDLE) begin
         bus.grant = owner;
      end
      if (state_q == ACCEPT) begin
         bus.ack = owner;
      end
      if ((state_q == DONE) || (state_q == ERR)) begin
         bus.done = owner;
      end
      if (state_q == ERR) begin
         bus.err = owner;
      end
   end

   assign bus.wr_start_en = (state_q == START) &&  cur_wr_q;
   assign bus.rd_start_en = (state_q == START) && !cur_wr_q;
   assign bus.wr_sec_addr = cur_addr_q;
   assign bus.rd_sec_addr = cur_addr_q;

endmodule

// File: tb/tb_sd_access_scheduler.sv
// tb/tb_sd_access_scheduler.sv - scoreboard bench for sd_access_scheduler
module tb_sd_access_scheduler;

   logic clk_sd       = 1'b0;
   logic reset_n      = 1'b0;
   logic sd_init_done = 1'b0;

   always #5 clk_sd = ~clk_sd;

   sd_access_scheduler_if ifc();

   sd_access_scheduler #(
      .START_TIMEOUT(8),
      .XFER_TIMEOUT (50)
   ) dut (
      .clk_sd      (clk_sd),
      .reset_n     (reset_n),
      .sd_init_done(sd_init_done),
      .bus         (ifc)
   );

   typedef struct {
      int          kind;
      logic [1:0]  v;
      logic [31:0] d;
   } ev_t;

   ev_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_ack    = 0;
   int n_start  = 0;
   int n_done   = 0;
   int last_ack_cyc   = 0;
   int last_start_cyc = 0;
   int last_done_cyc  = 0;
   int ack_gap        = 0;
   int drop_cyc       = 0;
   int busy_cnt       = 0;
   int busy_len       = 20;
   bit busy_en        = 1'b1;
   bit noise          = 1'b0;

   always @(posedge clk_sd) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%h required=%h (cycle %0d)", name, got, want, cyc);
   endtask

   task automatic push(input int kind, input logic [1:0] v, input logic [31:0] d);
      exp_q.push_back('{kind, v, d});
   endtask

   task automatic observe(input int kind, input logic [1:0] v, input logic [31:0] d);
      ev_t e;
      string nm;
      nm = (kind == 0) ? "sb_ack" : (kind == 1) ? "sb_start" : "sb_done";
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s unexpected event got v=%b d=%h required none (cycle %0d)", nm, v, d, cyc);
      end else begin
         e = exp_q.pop_front();
         check(nm, {28'd0, 2'(kind), v, d}, {28'd0, 2'(e.kind), e.v, e.d});
      end
   endtask

   // Monitor: every pulse the DUT presents is matched against the scoreboard in order.
   initial begin
      forever begin
         @(negedge clk_sd);
         if (ifc.ack != 2'b00) begin
            observe(0, ifc.ack, 32'd0);
            ack_gap      = cyc - last_done_cyc;
            last_ack_cyc = cyc;
            n_ack++;
         end
         if (ifc.wr_start_en || ifc.rd_start_en) begin
            observe(1, {ifc.wr_start_en, ifc.rd_start_en},
                    ifc.wr_start_en ? ifc.wr_sec_addr : ifc.rd_sec_addr);
            check("sec_addr_eq", ifc.wr_sec_addr, ifc.rd_sec_addr);
            last_start_cyc = cyc;
            n_start++;
         end
         if (ifc.done != 2'b00) begin
            observe(2, ifc.done, {30'd0, ifc.err});
            last_done_cyc = cyc;
            n_done++;
         end
      end
   end

   // Client request release on ack, and SD controller busy model.
   initial begin
      forever begin
         @(negedge clk_sd);
         if (ifc.ack[0]) ifc.req[0] = 1'b0;
         if (ifc.ack[1]) ifc.req[1] = 1'b0;
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               ifc.wr_busy = 1'b0;
               ifc.rd_busy = 1'b0;
            end
         end
         if (busy_en && ifc.wr_start_en) begin
            ifc.wr_busy = 1'b1;
            ifc.rd_busy = noise;
            busy_cnt    = busy_len;
         end
         if (busy_en && ifc.rd_start_en) begin
            ifc.rd_busy = 1'b1;
            ifc.wr_busy = noise;
            busy_cnt    = busy_len;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_sd);
         #1;
      end
   endtask

   task automatic wait_for(input int which, input int target, input int budget, input string name);
      int got;
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_sd);
         #1;
         got = (which == 0) ? n_ack : (which == 1) ? n_start : n_done;
         if (got >= target) begin
            hit = 1'b1;
            break;
         end
      end
      check(name, 64'(hit), 64'd1);
   endtask

   task automatic issue(input int c, input logic w, input logic [31:0] a, input logic [7:0] n);
      ifc.wr[c]          = w;
      ifc.addr[c*32 +: 32] = a;
      ifc.cnt[c*8 +: 8]  = n;
      ifc.req[c]         = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ack"},   ifc.ack, 0);
      check({tag, "_done"},  ifc.done, 0);
      check({tag, "_err"},   ifc.err, 0);
      check({tag, "_grant"}, ifc.grant, 0);
      check({tag, "_start"}, {ifc.wr_start_en, ifc.rd_start_en}, 0);
      check({tag, "_addr"},  {ifc.wr_sec_addr, ifc.rd_sec_addr}, 0);
   endtask

   initial begin
      ifc.req = 2'b00; ifc.wr = 2'b00; ifc.addr = 64'd0; ifc.cnt = 16'd0;
      ifc.wr_busy = 1'b0; ifc.rd_busy = 1'b0;

      // Reset state
      reset_n = 1'b0;
      idle(3);
      check_outputs_zero("rst");
      reset_n = 1'b1;
      sd_init_done = 1'b1;
      idle(2);

      // Three-sector write from client 0, unselected read busy held high
      busy_len = 20; noise = 1'b1;
      issue(0, 1'b1, 32'h10, 8'd3);
      push(0, 2'b01, 0);
      push(1, 2'b10, 32'h10);
      push(1, 2'b10, 32'h11);
      push(1, 2'b10, 32'h12);
      push(2, 2'b01, 0);
      wait_for(0, 1, 20, "t1_ack_wait");
      check("t1_grant", ifc.grant, 2'b01);
      wait_for(2, 1, 300, "t1_done_wait");
      idle(1);
      check("t1_grant_clr", ifc.grant, 0);
      noise = 1'b0;
      idle(3);

      // Simultaneous requests after reset: client 0 first, then client 1, then tie to client 0
      do_reset();
      busy_len = 4;
      issue(0, 1'b1, 32'h100, 8'd1);
      issue(1, 1'b0, 32'h200, 8'd1);
      push(0, 2'b01, 0); push(1, 2'b10, 32'h100); push(2, 2'b01, 0);
      push(0, 2'b10, 0); push(1, 2'b01, 32'h200); push(2, 2'b10, 0);
      wait_for(2, n_done + 2, 100, "t2_pair_wait");
      check("t2_ack_gap", ack_gap, 2);
      idle(2);
      issue(0, 1'b1, 32'h101, 8'd1);
      issue(1, 1'b0, 32'h201, 8'd1);
      push(0, 2'b01, 0); push(1, 2'b10, 32'h101); push(2, 2'b01, 0);
      push(0, 2'b10, 0); push(1, 2'b01, 32'h201); push(2, 2'b10, 0);
      wait_for(2, n_done + 2, 100, "t2_tie_wait");
      idle(2);

      // Address wrap on a two-sector read
      busy_len = 5;
      issue(1, 1'b0, 32'hFFFF_FFFF, 8'd2);
      push(0, 2'b10, 0);
      push(1, 2'b01, 32'hFFFF_FFFF);
      push(1, 2'b01, 32'h0000_0000);
      push(2, 2'b10, 0);
      wait_for(2, n_done + 1, 100, "t3_done_wait");
      idle(2);

      // Busy never rises: start timeout
      busy_en = 1'b0;
      issue(0, 1'b0, 32'h5, 8'd3);
      push(0, 2'b01, 0);
      push(1, 2'b01, 32'h5);
      push(2, 2'b01, 32'h1);
      wait_for(2, n_done + 1, 60, "t4_done_wait");
      check("t4_latency", last_done_cyc - last_start_cyc, 9);
      idle(1);
      check("t4_grant_clr", ifc.grant, 0);
      busy_en = 1'b1;
      idle(2);

      // Busy stuck high: transfer timeout
      busy_len = 80;
      issue(1, 1'b1, 32'h40, 8'd2);
      push(0, 2'b10, 0);
      push(1, 2'b10, 32'h40);
      push(2, 2'b10, 32'h2);
      wait_for(2, n_done + 1, 200, "t5_done_wait");
      idle(90);

      // Card lost during XFER, requests ignored until it returns
      busy_len = 20;
      issue(0, 1'b1, 32'h80, 8'd2);
      push(0, 2'b01, 0);
      push(1, 2'b10, 32'h80);
      push(2, 2'b01, 32'h1);
      wait_for(1, n_start + 1, 30, "t6_start_wait");
      idle(5);
      sd_init_done = 1'b0;
      drop_cyc = cyc;
      wait_for(2, n_done + 1, 10, "t6_done_wait");
      check("t6_err_latency", last_done_cyc - drop_cyc, 1);
      begin
         int a_base;
         a_base = n_ack;
         issue(1, 1'b0, 32'h300, 8'd1);
         idle(25);
         check("t6_no_ack", n_ack, a_base);
      end
      push(0, 2'b10, 0);
      push(1, 2'b01, 32'h300);
      push(2, 2'b10, 0);
      sd_init_done = 1'b1;
      wait_for(2, n_done + 1, 100, "t6_resume_wait");
      idle(2);

      // Zero-count request
      issue(1, 1'b1, 32'h400, 8'd0);
      push(0, 2'b10, 0);
      push(2, 2'b10, 0);
      wait_for(2, n_done + 1, 20, "t7_done_wait");
      check("t7_zero_gap", last_done_cyc - last_ack_cyc, 1);
      idle(2);

      // Reset mid-XFER aborts silently
      issue(0, 1'b1, 32'h500, 8'd2);
      push(0, 2'b01, 0);
      push(1, 2'b10, 32'h500);
      wait_for(1, n_start + 1, 30, "t8_start_wait");
      idle(4);
      reset_n = 1'b0;
      idle(1);
      check_outputs_zero("t8_rst");
      idle(1);
      reset_n = 1'b1;
      begin
         int d_base;
         d_base = n_done;
         idle(30);
         check("t8_no_done", n_done, d_base);
      end
      check("sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
